// File: rtl/spart_tx_bridge.sv
// spart_tx_bridge: claims CPU stores to SPART_ADDR, queues the low byte of
// each in a small FIFO and serializes queued bytes as 8N1 UART frames.
//   clk            : single clock, all state on posedge
//   rst            : synchronous active-low reset
//   spart_wrt_en   : store valid
//   spart_wrt_add  : store address
//   spart_wrt_data : store data, [7:0] used
//   txd            : registered serial output, idle high
//   tx_busy        : frame in progress or FIFO non-empty
//   fifo_count     : queued bytes, excluding the one being shifted
//   overflow       : sticky, set when a claimed store is dropped
module spart_tx_bridge #(
  parameter logic [31:0] SPART_ADDR   = 32'h0000_C000,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spart_wrt_en,
  input  logic [31:0]                   spart_wrt_add,
  input  logic [31:0]                   spart_wrt_data,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_n;
  logic [BW-1:0]   r_baud, w_baud_n;
  logic [2:0]      r_idx, w_idx_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_txd, w_txd_n;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [7:0]      r_mem [FIFO_DEPTH];

  logic w_push, w_pop, w_accept, w_bit_end, w_nonempty;
  logic w_unused_data;

  assign w_unused_data = ^spart_wrt_data[31:8];

  assign w_push     = spart_wrt_en && (spart_wrt_add == SPART_ADDR);
  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_nonempty = (r_count != '0);
  // A full FIFO still accepts when a pop frees a slot on the same edge.
  assign w_accept   = w_push && ((r_count < DEPTH_C) || w_pop);

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = w_bit_end ? '0 : r_baud + BW'(1);
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_n = '0;
        if (w_nonempty) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rd_ptr];
          w_idx_n   = '0;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_n = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
            w_state_n = S_STOP;
          end else begin
            w_shift_n = {1'b0, r_shift[7:1]};
            w_idx_n   = r_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (w_nonempty) begin
            w_pop     = 1'b1;
            w_shift_n = r_mem[r_rd_ptr];
            w_idx_n   = '0;
            w_state_n = S_START;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // txd is registered from the next-state view so it changes on the
    // same edge as the state it represents.
    case (w_state_n)
      S_START: w_txd_n = 1'b0;
      S_DATA:  w_txd_n = w_shift_n[0];
      default: w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_txd   <= w_txd_n;
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_accept) r_ovf <= 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_accept) r_mem[r_wr_ptr] <= spart_wrt_data[7:0];
  end

  assign txd        = r_txd;
  assign tx_busy    = (r_state != S_IDLE) || w_nonempty;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_spart_tx_bridge.sv
// Bench for spart_tx_bridge: directed scenarios plus random stores, every
// cycle compared against a queue-based frame model.
module tb_spart_tx_bridge;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [31:0] ADDR = 32'h0000_C000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [31:0] add = '0;
  logic [31:0] data = '0;
  logic        txd, busy, ovf;
  logic [2:0]  cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: queued bytes, current frame byte and position in frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = '0;
  int         m_pos = 0;
  bit         m_act = 0;
  bit         m_ovf = 0;

  logic       txd_tr[$];
  logic       busy_tr[$];

  always #5 clk = ~clk;

  spart_tx_bridge #(
    .SPART_ADDR  (ADDR),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .spart_wrt_en  (en),
    .spart_wrt_add (add),
    .spart_wrt_data(data),
    .txd           (txd),
    .tx_busy       (busy),
    .fifo_count    (cnt),
    .overflow      (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_txd();
    int b;
    if (!m_act) return 1'b1;
    b = m_pos / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  task automatic m_step();
    bit claim, fin, pop, room;
    if (!rst) begin
      m_q.delete();
      m_act = 0;
      m_pos = 0;
      m_ovf = 0;
    end else begin
      claim = en && (add == ADDR);
      fin   = m_act && (m_pos == 10*C - 1);
      pop   = (m_q.size() > 0) && (!m_act || fin);
      room  = (m_q.size() < D) || pop;
      if (m_act) m_pos++;
      if (fin) m_act = 0;
      if (pop) begin
        m_cur = m_q.pop_front();
        m_act = 1;
        m_pos = 0;
      end
      if (claim) begin
        if (room) m_q.push_back(data[7:0]);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [31:0] a, input logic [31:0] d);
    rst = r; en = e; add = a; data = d;
    @(posedge clk);
    m_step();
    #1;
    txd_tr.push_back(txd);
    busy_tr.push_back(busy);
    chk("txd",   32'(txd),  32'(m_txd()));
    chk("busy",  32'(busy), 32'(m_act || (m_q.size() > 0)));
    chk("count", 32'(cnt),  32'(m_q.size()));
    chk("ovf",   32'(ovf),  32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    logic [9:0] fb;
    logic [31:0] a;
    int sel;

    // Reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0);
    chk("rst_txd",  32'(txd),  32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt",  32'(cnt),  32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    idle(50);

    // Single byte 0xA5
    cyc(1'b1, 1'b1, ADDR, 32'h1234_56A5);
    chk("sb_cnt", 32'(cnt), 32'd1);
    txd_tr.delete(); busy_tr.delete();
    idle(1);
    chk("sb_start", 32'(txd), 32'd0);
    chk("sb_cnt0",  32'(cnt), 32'd0);
    idle(44);
    fb = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < C; j++)
        chk("sb_bit", 32'(txd_tr[C*k+j]), 32'(fb[k]));
    chk("sb_busy39", 32'(busy_tr[39]), 32'd1);
    chk("sb_busy40", 32'(busy_tr[40]), 32'd0);

    // Address filter
    cyc(1'b1, 1'b1, ADDR + 32'd4, 32'h55);
    cyc(1'b1, 1'b1, 32'd0, 32'h66);
    cyc(1'b1, 1'b0, ADDR, 32'h77);
    chk("af_cnt", 32'(cnt), 32'd0);
    chk("af_txd", 32'(txd), 32'd1);
    chk("af_ovf", 32'(ovf), 32'd0);
    idle(5);

    // Back-to-back 01,02,03
    txd_tr.delete(); busy_tr.delete();
    cyc(1'b1, 1'b1, ADDR, 32'h01); chk("bb_c1", 32'(cnt), 32'd1);
    cyc(1'b1, 1'b1, ADDR, 32'h02); chk("bb_c2", 32'(cnt), 32'd1);
    cyc(1'b1, 1'b1, ADDR, 32'h03); chk("bb_c3", 32'(cnt), 32'd2);
    idle(125);
    for (int f = 0; f < 3; f++) begin
      fb = {1'b1, 8'(f + 1), 1'b0};
      for (int k = 0; k < 10; k++)
        chk("bb_bit", 32'(txd_tr[1 + 40*f + C*k + 2]), 32'(fb[k]));
    end
    chk("bb_gap0s", 32'(txd_tr[40]), 32'd1);
    chk("bb_gap0n", 32'(txd_tr[41]), 32'd0);
    chk("bb_gap1s", 32'(txd_tr[80]), 32'd1);
    chk("bb_gap1n", 32'(txd_tr[81]), 32'd0);
    chk("bb_end",   32'(busy_tr[121]), 32'd0);

    // Overflow: 0x10..0x16
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b1, ADDR, 32'(8'h10 + i));
      if (i == 4) chk("ov_before", 32'(ovf), 32'd0);
      if (i == 5) chk("ov_set",    32'(ovf), 32'd1);
    end
    idle(220);
    chk("ov_sticky", 32'(ovf), 32'd1);
    chk("ov_drain",  32'(cnt), 32'd0);

    // Reset during data bit 3 of the first of two queued bytes
    cyc(1'b1, 1'b1, ADDR, 32'h5A);
    cyc(1'b1, 1'b1, ADDR, 32'hC3);
    idle(17);
    cyc(1'b0, 1'b0, '0, '0);
    chk("mr_txd", 32'(txd), 32'd1);
    chk("mr_cnt", 32'(cnt), 32'd0);
    idle(60);
    chk("mr_busy", 32'(busy), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      sel = int'($urandom % 4);
      case (sel)
        0, 1:    a = ADDR;
        2:       a = ADDR + 32'd4;
        default: a = $urandom;
      endcase
      cyc(($urandom % 400) != 0, ($urandom % 12) == 0, a, $urandom);
    end
    idle(300);
    chk("rnd_drain", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
